// File: rtl/nonce_sched.sv
// Nonce block scheduler: deals 2^BLK_BITS-nonce blocks round-robin to idle cores, arbitrates found nonces into
// the result FIFO (found->fifo_wr 1 cycle, grants stall while fifo_full). NONCE_SCHED_STATS_EN adds block/result counters.
module nonce_sched #(
  parameter int NCORES   = 4,
  parameter int NONCE_W  = 32,
  parameter int BLK_BITS = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_load,
  input  logic                      receiving,
  input  logic [NCORES-1:0]         core_busy,
  output logic [NCORES-1:0]         core_start,
  output logic [NONCE_W-1:0]        core_base,
  output logic                      core_abort,
  input  logic [NCORES-1:0]         core_found,
  input  logic [NCORES*NONCE_W-1:0] core_nonce,
  output logic [NCORES-1:0]         core_ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [NONCE_W-1:0]        fifo_data,
  output logic                      running,
  output logic                      exhausted
`ifdef NONCE_SCHED_STATS_EN
  ,
  output logic [31:0]               blocks_sent,
  output logic [31:0]               results_sent
`endif
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [NONCE_W:0] BLK_INC = (NONCE_W+1)'(1) << BLK_BITS;

  typedef enum logic [2:0] {S_IDLE, S_ABORT, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [NONCE_W-1:0]   next_base;
  logic [PW-1:0]        disp_ptr, res_ptr;
  logic [NCORES-1:0]    pend, pend_age;
  logic [PW:0]          disp_pick, res_pick;
  logic [NONCE_W:0]     base_sum;
  logic [PW-1:0]        start_idx, grant_idx;
  logic                 do_start, do_grant, grant_wr, drain_done;

  // Returns {valid, index} of the first set request at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NCORES-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] pick;
    int          j;
    pick = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NCORES;
      if (req[j[PW-1:0]]) pick = {1'b1, j[PW-1:0]};
    end
    return pick;
  endfunction

  assign disp_pick = rr_pick(~core_busy & ~pend, disp_ptr);
  assign res_pick  = rr_pick(core_found & ~core_ack, res_ptr);
  assign base_sum  = {1'b0, next_base} + BLK_INC;
  assign start_idx = disp_pick[PW-1:0];
  assign grant_idx = res_pick[PW-1:0];

  always_comb begin
    state_nx   = state;
    do_start   = 1'b0;
    do_grant   = 1'b0;
    grant_wr   = 1'b0;
    drain_done = 1'b0;
    case (state)
      S_ABORT: begin
        if (core_busy == '0 && core_found == '0) state_nx = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (!receiving && disp_pick[PW]) begin
          do_start = 1'b1;
          if (base_sum[NONCE_W]) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // pend keeps the final block's core from being mistaken for idle before it reports busy
        if (core_busy == '0 && core_found == '0 && !fifo_wr && pend == '0) begin
          state_nx   = S_DONE;
          drain_done = 1'b1;
        end
      end
      default: ;
    endcase
    if (res_pick[PW]) begin
      if (state == S_ABORT) begin
        do_grant = 1'b1;
      end else if (!fifo_full) begin
        do_grant = 1'b1;
        grant_wr = 1'b1;
      end
    end
    if (job_load) begin
      state_nx   = S_ABORT;
      do_start   = 1'b0;
      do_grant   = 1'b0;
      grant_wr   = 1'b0;
      drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      next_base  <= '0;
      disp_ptr   <= '0;
      res_ptr    <= '0;
      pend       <= '0;
      pend_age   <= '0;
      core_start <= '0;
      core_base  <= '0;
      core_abort <= 1'b0;
      core_ack   <= '0;
      fifo_wr    <= 1'b0;
      fifo_data  <= '0;
      running    <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      state      <= state_nx;
      running    <= (state_nx == S_DISPATCH) || (state_nx == S_DRAIN);
      core_abort <= job_load;
      core_start <= do_start ? (NCORES'(1) << start_idx) : '0;
      core_ack   <= do_grant ? (NCORES'(1) << grant_idx) : '0;
      fifo_wr    <= grant_wr;
      if (grant_wr) begin
        fifo_data <= core_nonce[grant_idx*NONCE_W +: NONCE_W];
        res_ptr   <= PW'((int'(grant_idx) + 1) % NCORES);
      end
      if (drain_done) exhausted <= 1'b1;
      // a pending core is released once it reports busy, or after two cycles regardless
      pend     <= pend & ~core_busy & ~pend_age;
      pend_age <= pend & ~core_busy & ~pend_age;
      if (do_start) begin
        pend[start_idx] <= 1'b1;
        core_base       <= next_base;
        next_base       <= base_sum[NONCE_W-1:0];
        disp_ptr        <= PW'((int'(start_idx) + 1) % NCORES);
      end
      if (job_load) begin
        next_base <= '0;
        exhausted <= 1'b0;
        disp_ptr  <= '0;
        pend      <= '0;
        pend_age  <= '0;
      end
    end
  end

`ifdef NONCE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blocks_sent  <= '0;
      results_sent <= '0;
    end else if (job_load) begin
      blocks_sent  <= '0;
      results_sent <= '0;
    end else begin
      if (core_start != '0 && blocks_sent != '1) blocks_sent <= blocks_sent + 32'd1;
      if (fifo_wr && results_sent != '1) results_sent <= results_sent + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_sched.sv
// Bench for nonce_sched: one instance at BLK_BITS=20 driven by a behavioural core model, one at BLK_BITS=28
// with permanently idle cores for the exhaustion scenario.
`timescale 1ns/1ps
module tb_nonce_sched;
  localparam int NC = 4;
  localparam int NW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             job_load, receiving, fifo_full;
  logic [NC-1:0]    core_busy, core_found, core_start, core_ack;
  logic [NC*NW-1:0] core_nonce;
  logic [NW-1:0]    core_base, fifo_data;
  logic             core_abort, fifo_wr, running, exhausted;

  logic             job_load_b;
  logic             zero_bit;
  logic [NC-1:0]    zero_nc;
  logic [NC*NW-1:0] zero_nonce;
  logic [NC-1:0]    core_start_b, core_ack_b;
  logic [NW-1:0]    core_base_b, fifo_data_b;
  logic             core_abort_b, fifo_wr_b, running_b, exhausted_b;

`ifdef NONCE_SCHED_STATS_EN
  logic [31:0] blocks_a, results_a, blocks_b, results_b;
`endif

  int checks = 0;
  int errors = 0;
  int busy_left [NC];
  int busy_len;

  nonce_sched #(.NCORES(NC), .NONCE_W(NW), .BLK_BITS(20)) dut (
    .clk(clk), .rst(rst), .job_load(job_load), .receiving(receiving),
    .core_busy(core_busy), .core_start(core_start), .core_base(core_base),
    .core_abort(core_abort), .core_found(core_found), .core_nonce(core_nonce),
    .core_ack(core_ack), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .running(running), .exhausted(exhausted)
`ifdef NONCE_SCHED_STATS_EN
    , .blocks_sent(blocks_a), .results_sent(results_a)
`endif
  );

  nonce_sched #(.NCORES(NC), .NONCE_W(NW), .BLK_BITS(28)) dut_b (
    .clk(clk), .rst(rst), .job_load(job_load_b), .receiving(zero_bit),
    .core_busy(zero_nc), .core_start(core_start_b), .core_base(core_base_b),
    .core_abort(core_abort_b), .core_found(zero_nc), .core_nonce(zero_nonce),
    .core_ack(core_ack_b), .fifo_full(zero_bit), .fifo_wr(fifo_wr_b),
    .fifo_data(fifo_data_b), .running(running_b), .exhausted(exhausted_b)
`ifdef NONCE_SCHED_STATS_EN
    , .blocks_sent(blocks_b), .results_sent(results_b)
`endif
  );

  // Advance one cycle, sample 1ns after the edge, then let the core model react to what it sees.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (core_abort && core_start != '0) begin
      errors++;
      $display("FAIL abort_start_overlap: core_abort=%0b core_start=%b, required no start during abort", core_abort, core_start);
    end
    checks++;
    if (core_abort_b && core_start_b != '0) begin
      errors++;
      $display("FAIL abort_start_overlap_b: core_abort=%0b core_start=%b, required no start during abort", core_abort_b, core_start_b);
    end
    for (int i = 0; i < NC; i++) begin
      if (core_abort) busy_left[i] = 0;
      if (core_start[i]) busy_left[i] = busy_len;
      if (core_ack[i]) core_found[i] = 1'b0;
      core_busy[i] = (busy_left[i] > 0);
      if (busy_left[i] > 0) busy_left[i]--;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; job_load = 1'b0; receiving = 1'b0; fifo_full = 1'b0;
    core_busy = '0; core_found = '0; core_nonce = '0; job_load_b = 1'b0;
    zero_bit = 1'b0; zero_nc = '0; zero_nonce = '0; busy_len = 0;
    for (int i = 0; i < NC; i++) busy_left[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({core_start, core_abort, core_ack, fifo_wr, running, exhausted} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: start=%b abort=%b ack=%b wr=%b run=%b exh=%b, required all 0",
               core_start, core_abort, core_ack, fifo_wr, running, exhausted);
    end
    checks++;
    if (core_base !== '0 || fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_data: core_base=%h fifo_data=%h, required 0", core_base, fifo_data);
    end
    checks++;
    if ({core_start_b, core_abort_b, core_ack_b, fifo_wr_b, running_b, exhausted_b} !== '0 || core_base_b !== '0) begin
      errors++;
      $display("FAIL reset_b: start=%b base=%h run=%b exh=%b, required all 0", core_start_b, core_base_b, running_b, exhausted_b);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_dispatch();
    int n;
    logic [NC-1:0] es;
    logic [NW-1:0] eb;
    busy_len = 1000;
    job_load = 1'b1;
    tick();
    job_load = 1'b0;
    checks++;
    if (core_abort !== 1'b1 || core_start !== '0) begin
      errors++;
      $display("FAIL abort_pulse: core_abort=%b core_start=%b, required 1 and 0000", core_abort, core_start);
    end
    tick();
    checks++;
    if (core_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_width: core_abort=%b on second cycle, required 0", core_abort);
    end
    n = 0;
    while (core_start == '0 && n < 8) begin tick(); n++; end
    for (int k = 0; k < NC; k++) begin
      es = NC'(1) << k;
      eb = NW'(k) << 20;
      checks++;
      if (core_start !== es || core_base !== eb) begin
        errors++;
        $display("FAIL dispatch_%0d: core_start=%b core_base=%h, required %b %h", k, core_start, core_base, es, eb);
      end
      tick();
    end
    checks++;
    if (core_start !== '0 || running !== 1'b1) begin
      errors++;
      $display("FAIL dispatch_all_busy: core_start=%b running=%b, required 0000 and 1", core_start, running);
    end
  endtask

  task automatic test_results_pair();
    core_nonce[1*NW +: NW] = 32'h00123456;
    core_nonce[3*NW +: NW] = 32'h00345678;
    core_found = 4'b1010;
    fifo_full = 1'b0;
    tick();
    checks++;
    if (fifo_wr !== 1'b1 || fifo_data !== 32'h00123456 || core_ack !== 4'b0010) begin
      errors++;
      $display("FAIL pair_first: wr=%b data=%h ack=%b, required 1 00123456 0010", fifo_wr, fifo_data, core_ack);
    end
    tick();
    checks++;
    if (fifo_wr !== 1'b1 || fifo_data !== 32'h00345678 || core_ack !== 4'b1000) begin
      errors++;
      $display("FAIL pair_second: wr=%b data=%h ack=%b, required 1 00345678 1000", fifo_wr, fifo_data, core_ack);
    end
    tick();
    checks++;
    if (fifo_wr !== 1'b0 || core_ack !== '0) begin
      errors++;
      $display("FAIL pair_no_dup: wr=%b ack=%b, required 0 0000", fifo_wr, core_ack);
    end
  endtask

  task automatic test_fifo_full();
    fifo_full = 1'b1;
    core_nonce[2*NW +: NW] = 32'hCAFE0002;
    core_found[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (fifo_wr !== 1'b0 || core_ack !== '0) begin
        errors++;
        $display("FAIL full_hold_%0d: wr=%b ack=%b, required 0 0000", i, fifo_wr, core_ack);
      end
    end
    fifo_full = 1'b0;
    tick();
    checks++;
    if (fifo_wr !== 1'b1 || fifo_data !== 32'hCAFE0002 || core_ack !== 4'b0100) begin
      errors++;
      $display("FAIL full_release: wr=%b data=%h ack=%b, required 1 cafe0002 0100", fifo_wr, fifo_data, core_ack);
    end
  endtask

  task automatic test_random_results();
    logic [NW-1:0] exp_nonce [NC];
    bit            pend_exp  [NC];
    bit            prev_full, ok;
    int            idx, nb, left;
    for (int i = 0; i < NC; i++) pend_exp[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c < 350) begin
        for (int i = 0; i < NC; i++) begin
          if (!core_found[i] && $urandom_range(3) == 0) begin
            exp_nonce[i] = $urandom;
            core_nonce[i*NW +: NW] = exp_nonce[i];
            core_found[i] = 1'b1;
            pend_exp[i] = 1'b1;
          end
        end
        fifo_full = ($urandom_range(2) == 0);
      end else begin
        fifo_full = 1'b0;
      end
      prev_full = fifo_full;
      tick();
      idx = -1; nb = 0;
      for (int i = 0; i < NC; i++) if (core_ack[i]) begin idx = i; nb++; end
      if (fifo_wr) begin
        ok = (nb == 1) && !prev_full;
        if (ok) ok = pend_exp[idx] && (fifo_data === exp_nonce[idx]);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rand_write cycle %0d: data=%h ack=%b full_before=%b, required an outstanding nonce of the acked core",
                   c, fifo_data, core_ack, prev_full);
        end
        if (idx >= 0) pend_exp[idx] = 1'b0;
      end else begin
        checks++;
        if (core_ack !== '0) begin
          errors++;
          $display("FAIL rand_ack_no_write cycle %0d: ack=%b, required 0000", c, core_ack);
        end
      end
    end
    left = 0;
    for (int i = 0; i < NC; i++) if (pend_exp[i]) left++;
    checks++;
    if (left != 0 || core_found !== '0) begin
      errors++;
      $display("FAIL rand_lost: %0d results never written, found=%b, required 0 and 0000", left, core_found);
    end
  endtask

  task automatic test_abort();
    int n, abort_cnt;
    bit saw_ack, saw_wr;
    fifo_full = 1'b1;
    core_nonce[0 +: NW] = 32'hDEAD0000;
    core_found[0] = 1'b1;
    tick(); tick();
    checks++;
    if (fifo_wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre_hold: wr=%b, required 0", fifo_wr);
    end
    busy_len = 3;
    job_load = 1'b1;
    tick();
    job_load = 1'b0;
    fifo_full = 1'b0;
    checks++;
    if (running !== 1'b0 || core_start !== '0) begin
      errors++;
      $display("FAIL abort_state: running=%b start=%b, required 0 0000", running, core_start);
    end
    n = 0; abort_cnt = 0; saw_ack = 1'b0; saw_wr = 1'b0;
    while (core_start == '0 && n < 20) begin
      if (core_abort) abort_cnt++;
      if (core_ack[0]) saw_ack = 1'b1;
      if (fifo_wr) saw_wr = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (abort_cnt != 1 || !saw_ack || saw_wr) begin
      errors++;
      $display("FAIL abort_discard: abort_cycles=%0d acked=%b wrote=%b, required 1 1 0", abort_cnt, saw_ack, saw_wr);
    end
    checks++;
    if (core_start == '0 || core_base !== '0) begin
      errors++;
      $display("FAIL abort_restart: start=%b base=%h, required a start at base 00000000", core_start, core_base);
    end
  endtask

  task automatic test_receiving();
    int n, last_core;
    logic [NW-1:0] last_base, eb;
    logic [NC-1:0] es;
    n = 0;
    tick();
    while (core_start == '0 && n < 10) begin tick(); n++; end
    last_core = 0;
    for (int i = 0; i < NC; i++) if (core_start[i]) last_core = i;
    last_base = core_base;
    receiving = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (core_start !== '0) begin
        errors++;
        $display("FAIL recv_hold_%0d: core_start=%b, required 0000", i, core_start);
      end
    end
    receiving = 1'b0;
    tick();
    es = NC'(1) << ((last_core + 1) % NC);
    eb = last_base + 32'h00100000;
    checks++;
    if (core_start !== es || core_base !== eb) begin
      errors++;
      $display("FAIL recv_resume: core_start=%b core_base=%h, required %b %h", core_start, core_base, es, eb);
    end
  endtask

  task automatic test_exhaust();
    int cnt;
    logic [NW-1:0] eb;
    logic [NC-1:0] es;
    job_load_b = 1'b1;
    tick();
    job_load_b = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (core_start_b != '0) begin
        eb = NW'(cnt) << 28;
        es = NC'(1) << (cnt % NC);
        checks++;
        if (cnt >= 16 || core_base_b !== eb || core_start_b !== es || exhausted_b !== 1'b0) begin
          errors++;
          $display("FAIL exhaust_start_%0d: start=%b base=%h exh=%b, required %b %h 0 and at most 16 starts",
                   cnt, core_start_b, core_base_b, exhausted_b, es, eb);
        end
        cnt++;
      end
    end
    checks++;
    if (cnt != 16 || exhausted_b !== 1'b1 || running_b !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_done: starts=%0d exhausted=%b running=%b, required 16 1 0", cnt, exhausted_b, running_b);
    end
    job_load_b = 1'b1;
    tick();
    job_load_b = 1'b0;
    checks++;
    if (exhausted_b !== 1'b0 || core_abort_b !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_clear: exhausted=%b abort=%b, required 0 1", exhausted_b, core_abort_b);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_results_pair();
    test_fifo_full();
    test_random_results();
    test_abort();
    test_receiving();
    test_exhaust();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
